dmem_arbiter: RTL

Sequencing arbiter that shares the single-port data memory between two requesters: the pipeline LSU (port 0) and a DMA/debug master (port 1). It sits between the MEM stage's LSU memory-side signals and the `dmem` instance. It grants one transaction at a time, drives the memory for exactly one access cycle, and waits out the memory's fixed read latency. It then returns a registered completion with read data to the winning port.

---
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the dmem-side bus used by dmem_arbiter.
// slave = the arbiter's view; master = the requesters and memory around it.
interface dmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            p0_req,     p1_req;
  logic            p0_we,      p1_we;
  logic [XLEN-1:0] p0_addr,    p1_addr;
  logic [XLEN-1:0] p0_wdata,   p1_wdata;
  logic [3:0]      p0_byte_en, p1_byte_en;
  logic            p0_gnt,     p1_gnt;
  logic            p0_done,    p1_done;
  logic [XLEN-1:0] p0_rdata,   p1_rdata;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_byte_en;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_byte_en, p1_byte_en, mem_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
           mem_addr, mem_wdata, mem_byte_en, mem_wr_en, mem_rd_en, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_byte_en, p1_byte_en, mem_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
           mem_addr, mem_wdata, mem_byte_en, mem_wr_en, mem_rd_en, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Sequencing arbiter sharing single-port dmem between the LSU (port 0) and a DMA/debug master (port 1).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module dmem_arbiter #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t          state;
  logic            cmd_we;
  logic            cmd_port;
  logic [3:0]      lat_cnt;
  logic            grant;
  logic            win;
  logic            sel_we;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic [3:0]      sel_be;

`ifdef DMEM_ARB_RR_EN
  logic            last_gnt;
`endif

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    if (bus.p0_req && bus.p1_req) win = ~last_gnt;
    else                          win = ~bus.p0_req;
`else
    win = ~bus.p0_req;
`endif
    sel_we    = win ? bus.p1_we      : bus.p0_we;
    sel_addr  = win ? bus.p1_addr    : bus.p0_addr;
    sel_wdata = win ? bus.p1_wdata   : bus.p0_wdata;
    sel_be    = win ? bus.p1_byte_en : bus.p0_byte_en;
  end

  // Grant is combinational from IDLE; reset masks it so every output reads 0 while held.
  assign grant      = (state == IDLE) && (bus.p0_req || bus.p1_req) && !reset;
  assign bus.p0_gnt = grant && !win;
  assign bus.p1_gnt = grant &&  win;
  assign bus.busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cmd_we          <= 1'b0;
      cmd_port        <= 1'b0;
      lat_cnt         <= '0;
      bus.p0_done     <= 1'b0;
      bus.p1_done     <= 1'b0;
      bus.p0_rdata    <= '0;
      bus.p1_rdata    <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_byte_en <= '0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_rd_en   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_gnt        <= 1'b1;
`endif
    end else begin
      bus.p0_done     <= 1'b0;
      bus.p1_done     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_byte_en <= '0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_rd_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            // The captured command lands directly in the mem_* registers for the ACCESS cycle.
            cmd_we          <= sel_we;
            cmd_port        <= win;
            bus.mem_addr    <= sel_addr;
            bus.mem_wdata   <= sel_wdata;
            bus.mem_byte_en <= sel_be;
            bus.mem_wr_en   <= sel_we;
            bus.mem_rd_en   <= !sel_we;
            state           <= ACCESS;
`ifdef DMEM_ARB_RR_EN
            last_gnt        <= win;
`endif
          end
        end
        ACCESS: begin
          if (cmd_we) begin
            bus.p0_done <= !cmd_port;
            bus.p1_done <=  cmd_port;
            state       <= IDLE;
          end else begin
            lat_cnt <= 4'(MEM_LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            if (cmd_port) bus.p1_rdata <= bus.mem_rdata;
            else          bus.p0_rdata <= bus.mem_rdata;
            bus.p0_done <= !cmd_port;
            bus.p1_done <=  cmd_port;
            lat_cnt     <= '0;
            state       <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
